cpu_clock_ctrl: RTL and testbench
=================================

# cpu_clock_ctrl

Run/halt/single-step controller for the CPU clock enable. Replaces a free-running divided clock with a one-cycle `tick` enable pulse on the board clock, issued at a programmable rate in RUN mode or once per step command. It sits between the board clock/reset and the core's clock-enable input, and is driven by buttons (already synchronized) or a debug port.

## Interface
Parameters:
- `DIVIDER`, 25000000: reset-time tick period in `clk` cycles; must be ≥ 2.
- `CNT_W`, 32: width of the period counter, period register and `tick_count`.

Ports:
- `clk`, input, 1: board clock. This is the only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `run`, input, 1: one-cycle pulse that enters RUN.
- `halt`, input, 1: one-cycle pulse that enters HALTED.
- `step`, input, 1: one-cycle pulse that requests exactly one tick while HALTED.
- `div_wr`, input, 1: one-cycle pulse that loads `div_val`.
- `div_val`, input, CNT_W: new tick period in cycles. Values 0 and 1 are stored as 2.
- `pc`, input, 32: current CPU PC. Used only when the breakpoint feature is compiled in.
- `bp_addr`, input, 32: breakpoint address. Used only when the breakpoint feature is compiled in.
- `tick`, output, 1: registered one-cycle clock-enable pulse for the core.
- `running`, output, 1: high in RUN state.
- `tick_count`, output, CNT_W: total ticks issued. Wraps modulo 2^CNT_W.
- `bp_hit`, output, 1: sticky breakpoint flag. Held at 0 when the feature is compiled out.

## Operation
- States: HALTED, RUN, STEP. Reset state is HALTED.
- Command priority within one cycle: `halt` > `run` > `step`.
- HALTED:
  - `run` → RUN; clears `cnt` to 0.
  - `step` → STEP.
  - All other inputs: stay in HALTED.
- STEP:
  - Issues one tick, then returns to HALTED unconditionally.
  - `halt` in STEP does not cancel the tick.
  - `run` in STEP → RUN after the tick.
- RUN:
  - `cnt` increments every cycle. When `cnt == period-1`, the next cycle asserts `tick` and `cnt` returns to 0.
  - `halt` → HALTED, and any tick not yet registered is suppressed.
  - `step` is ignored.
- Period register:
  - Resets to `DIVIDER`.
  - On `div_wr`, the new value loads into `pend`. `pend` transfers to `period` at the next terminal count, or immediately when the state is not RUN. A running period therefore never shortens mid-count.
  - Back-to-back `div_wr` pulses: the last write wins.
- `tick_count` increments in the same cycle `tick` is asserted.
- Reset mid-operation: all registers clear asynchronously, and no tick is issued until a new command arrives.

## Timing
- Reset values:
  - `tick`=0, `running`=0, `tick_count`=0, `bp_hit`=0.
  - `cnt`=0, `period`=`DIVIDER`, state HALTED.
- All outputs are registered; there are no combinational input-to-output paths.
- Run latency: with `run` sampled at edge N, the first tick is high in cycle N+period. Subsequent ticks repeat every `period` cycles, each exactly 1 cycle wide.
- Step latency: with `step` sampled at edge N, the state is STEP in cycle N+1 and `tick` is high in cycle N+2. The state is HALTED again in cycle N+2.
- Halt: with `halt` sampled at edge N, `running` falls at N+1. No tick is high at or after N+1, even if the terminal count coincided with cycle N.
- `running` rises one cycle after `run` is sampled.

## Configuration
- Macro: `CPU_CLOCK_CTRL_BREAK_EN`.
- When defined:
  - In RUN, if a tick is issued and `pc == bp_addr` at the following cycle, the state goes to HALTED.
  - `bp_hit` sets and stays set until the next `run` or `step` clears it.
  - The breakpoint halt has the same priority as `halt`.
  - A `step` issued while `pc == bp_addr` still executes; a breakpoint does not block stepping.
- When undefined:
  - `pc` and `bp_addr` are unused.
  - `bp_hit` is tied to 0.
  - No comparator logic is synthesized.

## Test plan
- Reset check: assert `rst` for 3 cycles, then release → `tick`=0, `running`=0, `tick_count`=0; 50 idle cycles produce no tick.
- Run at `DIVIDER`=4 (build override): pulse `run` at cycle 10, then `halt` at cycle 25 → ticks in cycles 14, 18, 22 only; `tick_count`=3; `running` falls in cycle 26.
- Step: while HALTED, pulse `step` 3 times, 5 cycles apart; then pulse `step` during RUN → exactly one tick per HALTED step, each 2 cycles after its pulse; the RUN step adds nothing; step contribution to `tick_count` is 3.
- Divider reload: in RUN with period 4, write `div_val`=7 mid-count → the current interval stays 4, following intervals are 7. A write of `div_val`=0 yields interval 2.
- Simultaneous commands: `halt`+`run` in the same cycle while HALTED → stays HALTED. `run`+`step` in the same cycle → RUN with no extra tick.
- Breakpoint (`CPU_CLOCK_CTRL_BREAK_EN` defined): `bp_addr`=0x10, with `pc` advancing by 4 per tick from 0 → halt after the 4th tick with `bp_hit`=1. A following `step` clears `bp_hit` and issues one tick.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - run/halt/single-step tick enable for the CPU core
// Optional breakpoint halt compiled in with CPU_CLOCK_CTRL_BREAK_EN.
module cpu_clock_ctrl #(
    parameter int DIVIDER = 25000000,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_val,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] tick_count,
    output logic             bp_hit
);

    typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pend;
    logic             pend_vld;
    logic [CNT_W-1:0] div_sat;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic             tc_next;
    logic             load_now;
    logic             brk;

    assign div_sat  = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
    // tick is high in the cycle where cnt sits at period-1, so it is registered
    // one edge earlier; cnt wraps to 0 on the edge after the tick.
    assign wrap     = (cnt == period - CNT_W'(1));
    assign cnt_nxt  = wrap ? '0 : cnt + CNT_W'(1);
    assign tc_next  = (cnt_nxt == period - CNT_W'(1));
    assign load_now = (state != S_RUN) || wrap;

`ifdef CPU_CLOCK_CTRL_BREAK_EN
    logic tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_d <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            tick_d <= tick;
            if (state == S_RUN && brk)
                bp_hit <= 1'b1;
            else if (state != S_RUN && !halt && (run || step))
                bp_hit <= 1'b0;
        end
    end

    // pc has advanced past the ticked instruction in the cycle after the tick
    assign brk = tick_d && (pc == bp_addr);
`else
    logic unused_bp;

    assign unused_bp = ^{pc, bp_addr};
    assign brk       = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HALTED;
            cnt        <= '0;
            period     <= CNT_W'(DIVIDER);
            pend       <= '0;
            pend_vld   <= 1'b0;
            tick       <= 1'b0;
            running    <= 1'b0;
            tick_count <= '0;
        end else begin
            tick <= 1'b0;
            if (div_wr) begin
                pend     <= div_sat;
                pend_vld <= 1'b1;
            end
            if (load_now) begin
                if (div_wr) begin
                    period   <= div_sat;
                    pend_vld <= 1'b0;
                end else if (pend_vld) begin
                    period   <= pend;
                    pend_vld <= 1'b0;
                end
            end
            case (state)
                S_HALTED: begin
                    if (!halt && run) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        cnt     <= '0;
                    end else if (!halt && step) begin
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    tick       <= 1'b1;
                    tick_count <= tick_count + CNT_W'(1);
                    if (run && !halt) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        state <= S_HALTED;
                    end
                end
                S_RUN: begin
                    if (halt || brk) begin
                        state   <= S_HALTED;
                        running <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (tc_next) begin
                            tick       <= 1'b1;
                            tick_count <= tick_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= S_HALTED;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - directed self-checking bench for cpu_clock_ctrl
module tb_cpu_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic        step = 1'b0;
    logic        div_wr = 1'b0;
    logic [31:0] div_val = '0;
    logic [31:0] pc = '0;
    logic [31:0] bp_addr = 32'h10;
    logic        pc_clr = 1'b0;
    logic        tick;
    logic        running;
    logic [31:0] tick_count;
    logic        bp_hit;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick_log[$];
    int e;
    int m;

    cpu_clock_ctrl #(.DIVIDER(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .step(step),
        .div_wr(div_wr), .div_val(div_val), .pc(pc), .bp_addr(bp_addr),
        .tick(tick), .running(running), .tick_count(tick_count), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    // cyc numbers posedges; a tick registered at edge k is logged as k
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tick) tick_log.push_back(cyc);

    // core model: pc advances by 4 on every enabled cycle
    always @(posedge clk) begin
        if (pc_clr) pc <= '0;
        else if (tick) pc <= pc + 32'd4;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int log_at(input int idx);
        return (idx < tick_log.size()) ? tick_log[idx] : -1;
    endfunction

    // called at a negedge; returns at the next negedge with the sampling edge number
    task automatic cmd(input logic r, input logic h, input logic s, output int edge_n);
        run = r; halt = h; step = s;
        @(negedge clk);
        edge_n = cyc;
        run = 1'b0; halt = 1'b0; step = 1'b0;
    endtask

    task automatic wr_div(input logic [31:0] v, output int edge_n);
        div_wr = 1'b1; div_val = v;
        @(negedge clk);
        edge_n = cyc;
        div_wr = 1'b0;
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_bp_hit", bp_hit, 0);
        repeat (50) @(negedge clk);
        chk("idle_no_ticks", tick_log.size(), 0);

        // run at period 4, halt 15 edges later (coincides with a terminal count)
        m = tick_log.size();
        cmd(1, 0, 0, e);
        chk("run_running_rise", running, 1);
        repeat (14) @(negedge clk);
        cmd(0, 1, 0, e);
        chk("halt_running_fall", running, 0);
        repeat (10) @(negedge clk);
        chk("run_tick_n", tick_log.size() - m, 3);
        chk("run_tick0", log_at(m), e - 12);
        chk("run_tick1", log_at(m + 1), e - 8);
        chk("run_tick2", log_at(m + 2), e - 4);
        chk("run_count", tick_count, 3);

        // single steps while halted, 5 edges apart
        for (int i = 0; i < 3; i++) begin
            cmd(0, 0, 1, e);
            chk("step_no_early_tick", tick, 0);
            @(negedge clk);
            chk("step_tick", tick, 1);
            @(negedge clk);
            chk("step_tick_width", tick, 0);
            repeat (2) @(negedge clk);
        end
        chk("step_count", tick_count, 6);

        // step during RUN is ignored
        m = tick_log.size();
        cmd(1, 0, 0, e);
        @(negedge clk);
        cmd(0, 0, 1, e);
        repeat (2) @(negedge clk);
        cmd(0, 1, 0, e);
        chk("runstep_tick_n", tick_log.size() - m, 1);
        chk("runstep_tick0", log_at(m), e - 2);
        chk("runstep_count", tick_count, 7);

        // divider reload: 4 -> 7 mid-count, then 0 (stored as 2)
        m = tick_log.size();
        cmd(1, 0, 0, e);
        repeat (4) @(negedge clk);
        wr_div(32'd7, e);
        repeat (17) @(negedge clk);
        wr_div(32'd0, e);
        repeat (9) @(negedge clk);
        cmd(0, 1, 0, e);
        chk("div_tick_n", tick_log.size() - m, 7);
        chk("div_int_keep4", log_at(m + 1) - log_at(m), 4);
        chk("div_int_7a", log_at(m + 2) - log_at(m + 1), 7);
        chk("div_int_7b", log_at(m + 3) - log_at(m + 2), 7);
        chk("div_int_7c", log_at(m + 4) - log_at(m + 3), 7);
        chk("div_int_2a", log_at(m + 5) - log_at(m + 4), 2);
        chk("div_int_2b", log_at(m + 6) - log_at(m + 5), 2);
        chk("div_first", log_at(m), e - 30);
        wr_div(32'd4, e);

        // halt+run together while halted: halt wins
        m = tick_log.size();
        cmd(1, 1, 0, e);
        chk("haltrun_running", running, 0);
        repeat (8) @(negedge clk);
        chk("haltrun_no_ticks", tick_log.size() - m, 0);

        // run+step together: RUN with no step tick (period back at 4)
        cmd(1, 0, 1, e);
        chk("runstep_same_running", running, 1);
        repeat (3) @(negedge clk);
        cmd(0, 1, 0, e);
        chk("runstep_same_n", tick_log.size() - m, 1);
        chk("runstep_same_t0", log_at(m), e - 1);

        // halt during STEP keeps the tick
        cmd(0, 0, 1, e);
        cmd(0, 1, 0, e);
        chk("step_halt_tick", tick, 1);
        chk("step_halt_running", running, 0);
        @(negedge clk);
        chk("step_halt_tick_end", tick, 0);

        // run during STEP: tick, then RUN
        cmd(0, 0, 1, e);
        cmd(1, 0, 0, e);
        chk("step_run_tick", tick, 1);
        chk("step_run_running", running, 1);
        repeat (3) @(negedge clk);
        chk("step_run_next_tick", tick, 1);
        cmd(0, 1, 0, e);

        // asynchronous reset mid-run
        cmd(1, 0, 0, e);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_running", running, 0);
        chk("arst_count", tick_count, 0);
        chk("arst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        m = tick_log.size();
        repeat (20) @(negedge clk);
        chk("arst_no_ticks", tick_log.size() - m, 0);
        chk("arst_halted", running, 0);

`ifdef CPU_CLOCK_CTRL_BREAK_EN
        // breakpoint at 0x10 with pc advancing 4 per tick from 0
        pc_clr = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;
        bp_addr = 32'h10;
        m = tick_log.size();
        cmd(1, 0, 0, e);
        repeat (20) @(negedge clk);
        chk("bp_tick_n", tick_log.size() - m, 4);
        chk("bp_last_tick", log_at(m + 3), e + 15);
        chk("bp_hit_set", bp_hit, 1);
        chk("bp_running", running, 0);
        cmd(0, 0, 1, e);
        chk("bp_hit_clear", bp_hit, 0);
        @(negedge clk);
        chk("bp_step_tick", tick, 1);
        repeat (3) @(negedge clk);
        chk("bp_step_n", tick_log.size() - m, 5);
`else
        chk("bp_hit_tied", bp_hit, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
